uart_tx_ctrl: RTL and testbench

- Frame sequencer for the UART transmit path. It owns the start/data/parity/stop ordering and drives the serializer through SER_EN.
- It consumes SER_DONE to end the data phase and muxes start, serial data, parity and stop onto the line.
- It sits between the TX FIFO/ALU-result source (DATA_VALID, P_DATA) and the TX pin. It runs entirely in the UART TX clock domain, one CLK per bit.

---
 rtl/uart_tx_ctrl_if.sv | 45 ++++
 rtl/uart_tx_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
// Signal bundle between the UART TX frame sequencer, its word source, the
// serializer and the TX pin.
//
//   DATA_VALID  source -> ctrl  request to send P_DATA
//   P_DATA      source -> ctrl  payload word
//   PAR_EN      source -> ctrl  parity bit present in frame
//   PAR_TYP     source -> ctrl  0 = even, 1 = odd parity
//   SER_DATA    ser    -> ctrl  current serial data bit
//   SER_DONE    ser    -> ctrl  serializer is presenting its last bit
//   SER_EN      ctrl   -> ser   serializer shift enable
//   BUSY        ctrl   -> src   frame in progress, request not accepted
//   TX_OUT      ctrl   -> pin   UART line
//   FRAME_DONE  ctrl   -> src   one-cycle pulse after the stop bit
//   TO_ERR      ctrl   -> src   sticky data-phase timeout flag
//
// master: the side surrounding the sequencer (source + serializer + pin).
// slave : the sequencer itself.
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  DATA_VALID;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  SER_DATA;
    logic                  SER_DONE;
    logic                  SER_EN;
    logic                  BUSY;
    logic                  TX_OUT;
    logic                  FRAME_DONE;
    logic                  TO_ERR;

    modport master (
        output DATA_VALID, P_DATA, PAR_EN, PAR_TYP, SER_DATA, SER_DONE,
        input  SER_EN, BUSY, TX_OUT, FRAME_DONE, TO_ERR
    );

    modport slave (
        input  DATA_VALID, P_DATA, PAR_EN, PAR_TYP, SER_DATA, SER_DONE,
        output SER_EN, BUSY, TX_OUT, FRAME_DONE, TO_ERR
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Frame sequencer for the UART transmit path. Orders start, data, optional
// parity and stop bits, enables the serializer during the data phase and
// muxes the proper bit onto TX_OUT. One CLK per bit.
//
// Ports:
//   CLK  bit-rate clock
//   RST  asynchronous active-low reset
//   bus  uart_tx_ctrl_if.slave (request/payload in, serializer handshake,
//        line output and status flags)
//
// Parameters:
//   DATA_WIDTH  payload bits per frame
//   TO_MARGIN   extra DATA cycles tolerated before declaring a timeout
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TO_MARGIN  = 2
) (
    input  logic         CLK,
    input  logic         RST,
    uart_tx_ctrl_if.slave bus
);

    localparam int LIMIT_INT = DATA_WIDTH + TO_MARGIN;
    localparam int CNT_W     = $clog2(LIMIT_INT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT_INT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             par_en_reg, par_en_next;
    logic             par_bit_reg, par_bit_next;
    logic             to_err_reg, to_err_next;
    logic             frame_done_reg;

    logic             tx_out;
    logic             ser_en;
    logic             busy;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_reg + CNT_ONE;

    // -----------------------------------------------------------------------
    // State and status registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            par_en_reg     <= 1'b0;
            par_bit_reg    <= 1'b0;
            to_err_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            par_en_reg     <= par_en_next;
            par_bit_reg    <= par_bit_next;
            to_err_reg     <= to_err_next;
            // Pulse follows every STOP cycle, whatever comes next.
            frame_done_reg <= (state_reg == ST_STOP);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        par_en_next  = par_en_reg;
        par_bit_next = par_bit_reg;
        to_err_next  = to_err_reg;
        accept       = 1'b0;
        tx_out       = 1'b1;
        ser_en       = 1'b0;
        busy         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.DATA_VALID) begin
                    accept = 1'b1;
                end
            end

            ST_START: begin
                tx_out     = 1'b0;
                busy       = 1'b1;
                cnt_next   = '0;
                state_next = ST_DATA;
            end

            ST_DATA: begin
                // Serial bit passes straight through so the serializer
                // output lands on the line in the same cycle.
                tx_out   = bus.SER_DATA;
                ser_en   = 1'b1;
                busy     = 1'b1;
                cnt_next = cnt_inc;
                if (bus.SER_DONE) begin
                    // SER_DONE takes priority over a coincident timeout.
                    state_next = par_en_reg ? ST_PARITY : ST_STOP;
                end else if (cnt_inc == CNT_LIMIT) begin
                    to_err_next = 1'b1;
                    state_next  = ST_STOP;
                end
            end

            ST_PARITY: begin
                tx_out     = par_bit_reg;
                busy       = 1'b1;
                state_next = ST_STOP;
            end

            ST_STOP: begin
                // BUSY is low here so the source can hand over the next word
                // and the frames run back-to-back without an idle bit.
                if (bus.DATA_VALID) begin
                    accept = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (accept) begin
            par_en_next  = bus.PAR_EN;
            par_bit_next = (^bus.P_DATA) ^ bus.PAR_TYP;
            to_err_next  = 1'b0;
            state_next   = ST_START;
        end
    end

    assign bus.TX_OUT     = tx_out;
    assign bus.SER_EN     = ser_en;
    assign bus.BUSY       = busy;
    assign bus.FRAME_DONE = frame_done_reg;
    assign bus.TO_ERR     = to_err_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Directed bench for uart_tx_ctrl. A small serializer model shifts the
// accepted word out LSB first while SER_EN is high and raises SER_DONE on a
// selectable data cycle (or never). Each frame is checked cycle by cycle
// against hand-built TX_OUT / SER_EN / BUSY / FRAME_DONE bit vectors.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    logic CLK;
    logic RST;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(
        .DATA_WIDTH(8),
        .TO_MARGIN (2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Serializer model
    logic [7:0] ser_word = 8'h00;
    logic [3:0] ser_idx  = 4'd0;
    logic [3:0] done_idx = 4'd7;
    logic       ser_done_en = 1'b1;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ser_idx <= 4'd0;
        end else begin
            if (bus.SER_EN) ser_idx <= ser_idx + 4'd1;
            else            ser_idx <= 4'd0;
            if (bus.DATA_VALID && !bus.BUSY) ser_word <= bus.P_DATA;
        end
    end

    assign bus.SER_DATA = ser_word[ser_idx[2:0]];
    assign bus.SER_DONE = bus.SER_EN && ser_done_en && (ser_idx == done_idx);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Accepts one frame and checks n cycles starting at the START cycle.
    // drop_at: cycle index after which DATA_VALID is released.
    task automatic run_frame(input string tag, input logic [7:0] data,
                             input logic pen, input logic ptyp,
                             input logic [31:0] exp_tx, input logic [31:0] exp_en,
                             input logic [31:0] exp_busy, input logic [31:0] exp_fd,
                             input int n, input int drop_at, input logic [7:0] next_data);
        bus.P_DATA     = data;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.DATA_VALID = 1'b1;
        step();
        bus.P_DATA = next_data;
        if (drop_at == 0) begin
            // Frame settings changing mid-frame must not disturb it.
            bus.PAR_EN  = ~pen;
            bus.PAR_TYP = ~ptyp;
        end
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.tx[%0d]", tag, i),   32'(bus.TX_OUT),     32'(exp_tx[i]));
            chk($sformatf("%s.en[%0d]", tag, i),   32'(bus.SER_EN),     32'(exp_en[i]));
            chk($sformatf("%s.busy[%0d]", tag, i), 32'(bus.BUSY),       32'(exp_busy[i]));
            chk($sformatf("%s.fd[%0d]", tag, i),   32'(bus.FRAME_DONE), 32'(exp_fd[i]));
            if (i == drop_at) bus.DATA_VALID = 1'b0;
            if (i != n - 1) step();
        end
        $display("frame %s data=%02h pen=%0d ptyp=%0d cycles=%0d", tag, data, pen, ptyp, n);
    endtask

    initial begin
        RST            = 1'b1;
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        #2 RST = 1'b0;
        step();
        step();
        chk("rst.tx",   32'(bus.TX_OUT),     32'd1);
        chk("rst.busy", 32'(bus.BUSY),       32'd0);
        chk("rst.en",   32'(bus.SER_EN),     32'd0);
        chk("rst.fd",   32'(bus.FRAME_DONE), 32'd0);
        chk("rst.err",  32'(bus.TO_ERR),     32'd0);
        #3 RST = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("idle.tx[%0d]", i),   32'(bus.TX_OUT),     32'd1);
            chk($sformatf("idle.busy[%0d]", i), 32'(bus.BUSY),       32'd0);
            chk($sformatf("idle.en[%0d]", i),   32'(bus.SER_EN),     32'd0);
            chk($sformatf("idle.fd[%0d]", i),   32'(bus.FRAME_DONE), 32'd0);
        end
        $display("idle 20 cycles");

        // Parity frames: {idle, stop, parity, data, start}, bit0 = START cycle
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 32'({1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}),
                  32'h1FE, 32'h3FF, 32'h800, 12, 0, 8'h5A);
        run_frame("01_odd",  8'h01, 1'b1, 1'b1, 32'({1'b1, 1'b1, 1'b0, 8'h01, 1'b0}),
                  32'h1FE, 32'h3FF, 32'h800, 12, 0, 8'hFE);
        run_frame("00_odd",  8'h00, 1'b1, 1'b1, 32'({1'b1, 1'b1, 1'b1, 8'h00, 1'b0}),
                  32'h1FE, 32'h3FF, 32'h800, 12, 0, 8'hFF);
        run_frame("07_even", 8'h07, 1'b1, 1'b0, 32'({1'b1, 1'b1, 1'b1, 8'h07, 1'b0}),
                  32'h1FE, 32'h3FF, 32'h800, 12, 0, 8'hF8);
        // No parity: 10-cycle frame
        run_frame("5a_nopar", 8'h5A, 1'b0, 1'b0, 32'({1'b1, 1'b1, 8'h5A, 1'b0}),
                  32'h1FE, 32'h1FF, 32'h400, 11, 0, 8'hA5);
        step();

        // Back-to-back 0x3C then 0xC3 with DATA_VALID held high
        run_frame("b2b", 8'h3C, 1'b1, 1'b0,
                  32'({1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}),
                  32'h000FF1FE, 32'h001FFBFF, 32'h00400800, 23, 11, 8'hC3);
        step();

        // Timeout: SER_DONE never comes, parity skipped
        ser_done_en = 1'b0;
        chk("to.err_before", 32'(bus.TO_ERR), 32'd0);
        run_frame("timeout", 8'hFF, 1'b1, 1'b0, 32'({1'b1, 1'b1, 10'h3FF, 1'b0}),
                  32'h7FE, 32'h7FF, 32'h1000, 13, 0, 8'h00);
        chk("to.err_set", 32'(bus.TO_ERR), 32'd1);
        step();
        step();
        chk("to.err_sticky", 32'(bus.TO_ERR), 32'd1);
        ser_done_en = 1'b1;

        // SER_DONE on the same edge the limit is reached: no timeout
        done_idx = 4'd9;
        run_frame("limit", 8'hFF, 1'b1, 1'b0, 32'({1'b1, 1'b1, 1'b0, 10'h3FF, 1'b0}),
                  32'h7FE, 32'hFFF, 32'h2000, 14, 0, 8'h00);
        chk("limit.err_clear", 32'(bus.TO_ERR), 32'd0);
        done_idx = 4'd7;
        step();

        // Reset during DATA bit 4
        bus.P_DATA     = 8'h5A;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        step();
        bus.DATA_VALID = 1'b0;
        repeat (5) step();
        chk("mid.en_bit4", 32'(bus.SER_EN), 32'd1);
        chk("mid.tx_bit4", 32'(bus.TX_OUT), 32'd1);
        chk("mid.busy",    32'(bus.BUSY),   32'd1);
        #2 RST = 1'b0;
        #1;
        chk("mid.rst_tx",   32'(bus.TX_OUT),     32'd1);
        chk("mid.rst_busy", 32'(bus.BUSY),       32'd0);
        chk("mid.rst_en",   32'(bus.SER_EN),     32'd0);
        chk("mid.rst_fd",   32'(bus.FRAME_DONE), 32'd0);
        step();
        chk("mid.fd_a", 32'(bus.FRAME_DONE), 32'd0);
        #3 RST = 1'b1;
        step();
        chk("mid.fd_b", 32'(bus.FRAME_DONE), 32'd0);
        chk("mid.tx_b", 32'(bus.TX_OUT),     32'd1);
        step();
        chk("mid.fd_c", 32'(bus.FRAME_DONE), 32'd0);
        $display("reset mid-frame");

        run_frame("post_rst", 8'h5A, 1'b1, 1'b0, 32'({1'b1, 1'b1, 1'b0, 8'h5A, 1'b0}),
                  32'h1FE, 32'h3FF, 32'h800, 12, 0, 8'h00);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
